// File: rtl/fmem_pingpong.sv
// Ping-pong banked frame memory: two R/W ports, 1-cycle registered reads with write-first forwarding,
// port A wins overlapping write collisions, idle-gated half swap; define FMEM_PARITY_EN for per-bank parity.
module fmem_pingpong #(
  parameter int DATA_W = 32,
  parameter int BANKS  = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    a_en,
  input  logic                    a_we,
  input  logic [BANKS-1:0]        a_bmask,
  input  logic [ADDR_W-1:0]       a_addr,
  input  logic [BANKS*DATA_W-1:0] a_wdata,
  output logic [BANKS*DATA_W-1:0] a_rdata,
  output logic                    a_rvalid,
  input  logic                    b_en,
  input  logic                    b_we,
  input  logic [BANKS-1:0]        b_bmask,
  input  logic [ADDR_W-1:0]       b_addr,
  input  logic [BANKS*DATA_W-1:0] b_wdata,
  input  logic                    b_same,
  output logic [BANKS*DATA_W-1:0] b_rdata,
  output logic                    b_rvalid,
  input  logic                    swap_req,
  output logic                    swap_ack,
  output logic                    sel,
  output logic                    collision,
  output logic                    a_perr,
  output logic                    b_perr
);

  localparam int W = BANKS * DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_ACK} swap_st_t;

  swap_st_t          r_st;
  swap_st_t          w_st_nxt;
  logic              r_sel;
  logic              w_swap_go;
  logic              w_idle;

  logic [ADDR_W:0]   w_a_pa;
  logic [ADDR_W:0]   w_b_pa;
  logic              w_same_pa;
  logic              w_a_wr, w_a_rd, w_b_wr, w_b_rd;
  logic [BANKS-1:0]  w_a_wmask, w_b_wmask;
  logic [BANKS-1:0]  w_a_fwd, w_b_fwd;
  logic              w_coll;
  logic [W-1:0]      w_a_rd_dat, w_b_rd_dat;

  logic [W-1:0]      r_a_rdata, r_b_rdata;
  logic              r_a_rvalid, r_b_rvalid;
  logic              r_collision;

  // Swap handshake: state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_st  <= S_IDLE;
      r_sel <= 1'b0;
    end else begin
      r_st <= w_st_nxt;
      if (w_swap_go) r_sel <= ~r_sel;
    end
  end

  assign w_idle = ~a_en & ~b_en;

  // A request seen during the ack cycle is only armed; it executes on a later idle edge.
  always_comb begin
    w_st_nxt  = r_st;
    w_swap_go = 1'b0;
    case (r_st)
      S_IDLE: begin
        if (swap_req) begin
          if (w_idle) begin
            w_st_nxt  = S_ACK;
            w_swap_go = 1'b1;
          end else begin
            w_st_nxt = S_PEND;
          end
        end
      end
      S_PEND: begin
        if (w_idle) begin
          w_st_nxt  = S_ACK;
          w_swap_go = 1'b1;
        end
      end
      S_ACK:   w_st_nxt = swap_req ? S_PEND : S_IDLE;
      default: w_st_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    swap_ack = (r_st == S_ACK);
  end

  assign sel = r_sel;

  assign w_a_pa    = {r_sel, a_addr};
  assign w_b_pa    = {(b_same ? r_sel : ~r_sel), b_addr};
  assign w_same_pa = (w_a_pa == w_b_pa);

  assign w_a_wr = a_en & a_we;
  assign w_a_rd = a_en & ~a_we;
  assign w_b_wr = b_en & b_we;
  assign w_b_rd = b_en & ~b_we;

  // Port B is masked off the banks port A also writes at the same location.
  assign w_a_wmask = {BANKS{w_a_wr}} & a_bmask;
  assign w_b_wmask = {BANKS{w_b_wr}} & b_bmask & ~({BANKS{w_same_pa}} & w_a_wmask);
  assign w_coll    = w_a_wr & w_b_wr & w_same_pa & (|(a_bmask & b_bmask));

`ifdef FMEM_PARITY_EN
  logic [BANKS-1:0]  w_a_pbad, w_b_pbad;
`endif

  for (genvar g = 0; g < BANKS; g++) begin : g_bank
    logic [DATA_W-1:0] r_mem [2*DEPTH];
    logic [DATA_W-1:0] w_a_wd, w_b_wd, w_a_q, w_b_q;

    assign w_a_wd = a_wdata[g*DATA_W +: DATA_W];
    assign w_b_wd = b_wdata[g*DATA_W +: DATA_W];
    assign w_a_q  = r_mem[w_a_pa];
    assign w_b_q  = r_mem[w_b_pa];

    always_ff @(posedge CLK) begin
      if (w_a_wmask[g]) r_mem[w_a_pa] <= w_a_wd;
      if (w_b_wmask[g]) r_mem[w_b_pa] <= w_b_wd;
    end

    assign w_a_fwd[g] = w_b_wr & w_same_pa & b_bmask[g];
    assign w_b_fwd[g] = w_a_wr & w_same_pa & a_bmask[g];

    assign w_a_rd_dat[g*DATA_W +: DATA_W] = w_a_fwd[g] ? w_b_wd : w_a_q;
    assign w_b_rd_dat[g*DATA_W +: DATA_W] = w_b_fwd[g] ? w_a_wd : w_b_q;

`ifdef FMEM_PARITY_EN
    logic r_par [2*DEPTH];

    always_ff @(posedge CLK) begin
      if (w_a_wmask[g]) r_par[w_a_pa] <= ^w_a_wd;
      if (w_b_wmask[g]) r_par[w_b_pa] <= ^w_b_wd;
    end

    // Forwarded banks never touched the array, so they cannot carry a parity fault.
    assign w_a_pbad[g] = ~w_a_fwd[g] & ((^w_a_q) ^ r_par[w_a_pa]);
    assign w_b_pbad[g] = ~w_b_fwd[g] & ((^w_b_q) ^ r_par[w_b_pa]);
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_a_rdata   <= '0;
      r_b_rdata   <= '0;
      r_a_rvalid  <= 1'b0;
      r_b_rvalid  <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      r_a_rvalid  <= w_a_rd;
      r_b_rvalid  <= w_b_rd;
      r_collision <= w_coll;
      if (w_a_rd) r_a_rdata <= w_a_rd_dat;
      if (w_b_rd) r_b_rdata <= w_b_rd_dat;
    end
  end

  assign a_rdata   = r_a_rdata;
  assign b_rdata   = r_b_rdata;
  assign a_rvalid  = r_a_rvalid;
  assign b_rvalid  = r_b_rvalid;
  assign collision = r_collision;

`ifdef FMEM_PARITY_EN
  logic r_a_perr, r_b_perr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_a_perr <= 1'b0;
      r_b_perr <= 1'b0;
    end else begin
      r_a_perr <= w_a_rd & (|w_a_pbad);
      r_b_perr <= w_b_rd & (|w_b_pbad);
    end
  end

  assign a_perr = r_a_perr;
  assign b_perr = r_b_perr;
`else
  assign a_perr = 1'b0;
  assign b_perr = 1'b0;
`endif

endmodule

// File: tb/tb_fmem_pingpong.sv
// Bench for fmem_pingpong: directed vectors with literal expectations plus a per-cycle reference model.
module tb_fmem_pingpong;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int DP = 16;
  localparam int AW = 4;
  localparam int W  = DW * NB;

  logic          CLK = 1'b0;
  logic          RST;
  logic          a_en, a_we, b_en, b_we, b_same, swap_req;
  logic [NB-1:0] a_bmask, b_bmask;
  logic [AW-1:0] a_addr, b_addr;
  logic [W-1:0]  a_wdata, b_wdata;
  logic [W-1:0]  a_rdata, b_rdata;
  logic          a_rvalid, b_rvalid, swap_ack, sel, collision, a_perr, b_perr;

  fmem_pingpong #(.DATA_W(DW), .BANKS(NB), .DEPTH(DP)) dut (
    .CLK(CLK), .RST(RST),
    .a_en(a_en), .a_we(a_we), .a_bmask(a_bmask), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_en(b_en), .b_we(b_we), .b_bmask(b_bmask), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_same(b_same), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .swap_req(swap_req), .swap_ack(swap_ack), .sel(sel), .collision(collision),
    .a_perr(a_perr), .b_perr(b_perr)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] fill(input int h, input int a, input int i);
    return 32'hC0DE0000 | 32'(h << 12) | 32'(a << 4) | 32'(i);
  endfunction

  // Reference model: memory as [half][addr][bank], swap as a pending flag.
  logic [DW-1:0] m_dat [2][DP][NB];
  logic          m_par [2][DP][NB];
  logic          m_sel = 0, m_pend = 0, m_ack = 0, m_coll = 0;
  logic          m_arv = 0, m_brv = 0, m_aperr = 0, m_bperr = 0;
  logic [W-1:0]  m_ard = '0, m_brd = '0;
  logic [W-1:0]  t_ra, t_rb;
  int            t_ha, t_hb;
  bit            t_same, t_pa, t_pb, t_p, t_idle;

  always @(posedge CLK) begin
    if (RST) begin
      m_sel = 0; m_pend = 0; m_ack = 0; m_coll = 0;
      m_arv = 0; m_brv = 0; m_aperr = 0; m_bperr = 0;
      m_ard = '0; m_brd = '0;
    end else begin
      t_ha   = int'(m_sel);
      t_hb   = b_same ? int'(m_sel) : int'(!m_sel);
      t_same = (t_ha == t_hb) && (a_addr == b_addr);
      t_pa = 0; t_pb = 0;
      t_ra = '0; t_rb = '0;
      for (int i = 0; i < NB; i++) begin
        if (b_en && b_we && t_same && b_bmask[i]) t_ra[i*DW +: DW] = b_wdata[i*DW +: DW];
        else begin
          t_ra[i*DW +: DW] = m_dat[t_ha][a_addr][i];
          if ((^m_dat[t_ha][a_addr][i]) !== m_par[t_ha][a_addr][i]) t_pa = 1;
        end
        if (a_en && a_we && t_same && a_bmask[i]) t_rb[i*DW +: DW] = a_wdata[i*DW +: DW];
        else begin
          t_rb[i*DW +: DW] = m_dat[t_hb][b_addr][i];
          if ((^m_dat[t_hb][b_addr][i]) !== m_par[t_hb][b_addr][i]) t_pb = 1;
        end
      end
`ifndef FMEM_PARITY_EN
      t_pa = 0; t_pb = 0;
`endif
      // B lands first so that A overwrites any shared bank.
      for (int i = 0; i < NB; i++) begin
        if (b_en && b_we && b_bmask[i]) begin
          m_dat[t_hb][b_addr][i] = b_wdata[i*DW +: DW];
          m_par[t_hb][b_addr][i] = ^b_wdata[i*DW +: DW];
        end
      end
      for (int i = 0; i < NB; i++) begin
        if (a_en && a_we && a_bmask[i]) begin
          m_dat[t_ha][a_addr][i] = a_wdata[i*DW +: DW];
          m_par[t_ha][a_addr][i] = ^a_wdata[i*DW +: DW];
        end
      end
      m_coll  = a_en && a_we && b_en && b_we && t_same && ((a_bmask & b_bmask) != 0);
      m_arv   = a_en && !a_we;
      m_brv   = b_en && !b_we;
      m_aperr = m_arv && t_pa;
      m_bperr = m_brv && t_pb;
      if (m_arv) m_ard = t_ra;
      if (m_brv) m_brd = t_rb;
      t_idle = !a_en && !b_en;
      if (m_ack) begin
        m_pend = swap_req;
        m_ack  = 0;
      end else begin
        t_p = m_pend || swap_req;
        if (t_p && t_idle) begin
          m_sel = !m_sel; m_pend = 0; m_ack = 1;
        end else begin
          m_pend = t_p; m_ack = 0;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("m_sel", sel, m_sel);
      check("m_swap_ack", swap_ack, m_ack);
      check("m_collision", collision, m_coll);
      check("m_a_rvalid", a_rvalid, m_arv);
      check("m_b_rvalid", b_rvalid, m_brv);
      check("m_a_rdata", a_rdata, m_ard);
      check("m_b_rdata", b_rdata, m_brd);
      check("m_a_perr", a_perr, m_aperr);
      check("m_b_perr", b_perr, m_bperr);
    end
  end

  task automatic idle();
    a_en = 0; a_we = 0; a_bmask = '0; a_addr = '0; a_wdata = '0;
    b_en = 0; b_we = 0; b_bmask = '0; b_addr = '0; b_wdata = '0;
    b_same = 0; swap_req = 0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic a_rd(input int addr);
    a_en = 1; a_we = 0; a_addr = AW'(addr);
  endtask

  task automatic b_rd(input int addr, input bit same);
    b_en = 1; b_we = 0; b_addr = AW'(addr); b_same = same;
  endtask

  initial begin
    idle();
    RST = 1;
    step(); step();
    chk_en = 1;
    check("rst_sel", sel, 1'b0);
    check("rst_swap_ack", swap_ack, 1'b0);
    check("rst_collision", collision, 1'b0);
    check("rst_a_rvalid", a_rvalid, 1'b0);
    check("rst_a_rdata", a_rdata, '0);
    check("rst_b_rdata", b_rdata, '0);
    RST = 0;

    // Known contents in both halves.
    for (int a = 0; a < DP; a++) begin
      a_en = 1; a_we = 1; a_bmask = '1; a_addr = AW'(a);
      b_en = 1; b_we = 1; b_bmask = '1; b_addr = AW'(a); b_same = 0;
      for (int i = 0; i < NB; i++) begin
        a_wdata[i*DW +: DW] = fill(0, a, i);
        b_wdata[i*DW +: DW] = fill(1, a, i);
      end
      step();
    end
    idle();

    a_en = 1; a_we = 1; a_bmask = '1; a_addr = 3; a_wdata = {4{32'h11111111}};
    step();
    idle(); a_rd(3); b_rd(3, 0);
    step();
    check("rd3_a_rvalid", a_rvalid, 1'b1);
    check("rd3_a_rdata", a_rdata, {4{32'h11111111}});
    check("rd3_b_other_half", b_rdata, 128'hC0DE1033_C0DE1032_C0DE1031_C0DE1030);
    idle();
    step();
    check("rvalid_pulse", a_rvalid, 1'b0);
    check("rdata_hold", a_rdata, {4{32'h11111111}});

    swap_req = 1;
    step();
    check("swap_sel", sel, 1'b1);
    check("swap_ack_pulse", swap_ack, 1'b1);
    swap_req = 0;
    step();
    check("swap_ack_clear", swap_ack, 1'b0);
    b_rd(3, 0);
    step();
    check("swap_b_sees_a", b_rdata, {4{32'h11111111}});
    idle();

    a_en = 1; a_we = 1; a_bmask = 4'b0011; a_addr = 5; a_wdata = {4{32'hAAAAAAAA}};
    b_rd(5, 1);
    step();
    check("fwd_b", b_rdata, 128'hC0DE1053_C0DE1052_AAAAAAAA_AAAAAAAA);
    idle(); a_rd(5); b_rd(5, 1);
    step();
    check("rr_a", a_rdata, 128'hC0DE1053_C0DE1052_AAAAAAAA_AAAAAAAA);
    check("rr_b", b_rdata, 128'hC0DE1053_C0DE1052_AAAAAAAA_AAAAAAAA);
    idle();

    a_en = 1; a_we = 1; a_bmask = 4'b0110; a_addr = 7; a_wdata = {4{32'hA0A0A0A0}};
    b_en = 1; b_we = 1; b_bmask = 4'b1100; b_addr = 7; b_wdata = {4{32'hB0B0B0B0}}; b_same = 1;
    step();
    check("coll_pulse", collision, 1'b1);
    idle();
    step();
    check("coll_clear", collision, 1'b0);
    a_rd(7);
    step();
    check("coll_readback", a_rdata, 128'hB0B0B0B0_A0A0A0A0_A0A0A0A0_C0DE1070);
    idle();

    b_en = 1; b_we = 1; b_bmask = 4'b1000; b_addr = 9; b_wdata = {4{32'h5A5A5A5A}}; b_same = 1;
    a_rd(9);
    step();
    check("fwd_a", a_rdata, 128'h5A5A5A5A_C0DE1092_C0DE1091_C0DE1090);
    idle();

    // Swap held off by four busy cycles.
    for (int k = 0; k < 4; k++) begin
      a_rd(k);
      swap_req = (k == 0);
      step();
      check("busy_no_swap", sel, 1'b1);
    end
    idle();
    step();
    check("idle_swap_sel", sel, 1'b0);
    check("idle_swap_ack", swap_ack, 1'b1);
    step();

    swap_req = 1;
    step();
    swap_req = 0;
    step();
    check("pre_rst_sel", sel, 1'b1);
    swap_req = 1; a_rd(3);
    step();
    swap_req = 0;
    RST = 1;
    step();
    check("rst_mid_sel", sel, 1'b0);
    check("rst_mid_rvalid", a_rvalid, 1'b0);
    RST = 0; idle();
    step();
    check("rst_drop_ack", swap_ack, 1'b0);
    check("rst_drop_sel", sel, 1'b0);

    swap_req = 1;
    step();
    check("held_1_ack", swap_ack, 1'b1);
    step();
    check("held_2_ack", swap_ack, 1'b0);
    step();
    check("held_3_sel", sel, 1'b0);
    check("held_3_ack", swap_ack, 1'b1);
    swap_req = 0;
    step(); step(); step();

    for (int n = 0; n < 80; n++) begin
      a_en = ($urandom_range(0, 3) != 0); a_we = $urandom_range(0, 1) != 0;
      a_bmask = NB'($urandom_range(0, 15)); a_addr = AW'($urandom_range(0, 3));
      b_en = ($urandom_range(0, 3) != 0); b_we = $urandom_range(0, 1) != 0;
      b_bmask = NB'($urandom_range(0, 15)); b_addr = AW'($urandom_range(0, 3));
      b_same = $urandom_range(0, 1) != 0;
      swap_req = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NB; i++) begin
        a_wdata[i*DW +: DW] = $urandom;
        b_wdata[i*DW +: DW] = $urandom;
      end
      step();
    end
    idle();
    step(); step(); step();

    a_en = 1; a_we = 1; a_bmask = '1; a_addr = 2; a_wdata = {4{32'h12345678}};
    step();
    idle();
`ifdef FMEM_PARITY_EN
    dut.g_bank[2].r_mem[{m_sel, 4'd2}][0] = ~dut.g_bank[2].r_mem[{m_sel, 4'd2}][0];
    m_dat[int'(m_sel)][2][2][0] = ~m_dat[int'(m_sel)][2][2][0];
    a_rd(2);
    step();
    check("perr_rvalid", a_rvalid, 1'b1);
    check("perr_flag", a_perr, 1'b1);
`else
    a_rd(2);
    step();
    check("perr_rvalid", a_rvalid, 1'b1);
    check("perr_off", a_perr, 1'b0);
`endif
    idle();
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
